// File: rtl/qoi_enc_accel.sv
// QOI image encoder accelerator on a small 6502-style register bus.
// Pixels are committed through byte latches, and the encoded QOI chunks are popped
// from an 8-entry output FIFO.
// Optional feature: define QOI_ENC_IRQ_EN for a registered irq = fifo_nonempty | err.
module qoi_enc_accel (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic [3:0] addr,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq
);
    typedef enum logic [1:0] {StIdle, StHash, StEmit} state_e;

    // Pixels are packed {R, G, B, A}, with R in the top byte.
    localparam logic [31:0] PrevInit = 32'h0000_00ff;

    state_e      state_q, state_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d, a_q, a_d;
    logic [31:0] px_q, px_d, prev_q, prev_d, entry_q, entry_d;
    logic [5:0]  run_q, run_d, hash_q, hash_d;
    logic [31:0] index_q [64];
    logic [31:0] index_d [64];
    logic [7:0]  fifo_q [8];
    logic [7:0]  fifo_d [8];
    logic [2:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;

    // Bus decode
    logic wr, rd, commit, start, flush, data_rd, pop;
    assign wr      = cs & we;
    assign rd      = cs & ~we;
    assign commit  = wr && (addr == 4'h3);
    assign start   = wr && (addr == 4'h4) && wdata[0];
    assign flush   = wr && (addr == 4'h4) && wdata[1];
    assign data_rd = rd && (addr == 4'h6);
    assign pop     = data_rd && (cnt_q != 4'd0);

    // Hash only needs the low 6 bits of each channel, because the sum is taken mod 64
    logic [5:0] h_calc;
    assign h_calc = px_q[29:24] * 6'd3 + px_q[21:16] * 6'd5 + px_q[13:8] * 6'd7 + px_q[5:0] * 6'd11;

    // Channel differences (8-bit wrap) and derived chunk fields
    logic [7:0]        dr_u, dg_u, db_u, rg_u, bg_u, dr2, dg2, db2, dg32, rg8, bg8;
    logic signed [7:0] dr, dg, db, rg, bg;
    logic [5:0]        run_m1;
    assign dr_u   = px_q[31:24] - prev_q[31:24];
    assign dg_u   = px_q[23:16] - prev_q[23:16];
    assign db_u   = px_q[15:8] - prev_q[15:8];
    assign rg_u   = dr_u - dg_u;
    assign bg_u   = db_u - dg_u;
    assign dr     = $signed(dr_u);
    assign dg     = $signed(dg_u);
    assign db     = $signed(db_u);
    assign rg     = $signed(rg_u);
    assign bg     = $signed(bg_u);
    assign dr2    = dr_u + 8'd2;
    assign dg2    = dg_u + 8'd2;
    assign db2    = db_u + 8'd2;
    assign dg32   = dg_u + 8'd32;
    assign rg8    = rg_u + 8'd8;
    assign bg8    = bg_u + 8'd8;
    assign run_m1 = run_q - 6'd1;

    logic [7:0] op [5];
    logic [2:0] op_n;
    logic [7:0] emit_b [6];
    logic [2:0] emit_n;

    // Classify the pixel held in px_q and build the byte sequence for EMIT
    always_comb begin
        for (int i = 0; i < 5; i++) op[i] = 8'h00;
        for (int i = 0; i < 6; i++) emit_b[i] = 8'h00;
        op_n   = 3'd0;
        emit_n = 3'd0;
        if (entry_q == px_q) begin
            op[0] = {2'b00, hash_q};
            op_n  = 3'd1;
        end else if (px_q[7:0] != prev_q[7:0]) begin
            op[0] = 8'hff;
            op[1] = px_q[31:24];
            op[2] = px_q[23:16];
            op[3] = px_q[15:8];
            op[4] = px_q[7:0];
            op_n  = 3'd5;
        end else if (dr >= -8'sd2 && dr <= 8'sd1 && dg >= -8'sd2 && dg <= 8'sd1 &&
                     db >= -8'sd2 && db <= 8'sd1) begin
            op[0] = {2'b01, dr2[1:0], dg2[1:0], db2[1:0]};
            op_n  = 3'd1;
        end else if (dg >= -8'sd32 && dg <= 8'sd31 && rg >= -8'sd8 && rg <= 8'sd7 &&
                     bg >= -8'sd8 && bg <= 8'sd7) begin
            op[0] = {2'b10, dg32[5:0]};
            op[1] = {rg8[3:0], bg8[3:0]};
            op_n  = 3'd2;
        end else begin
            op[0] = 8'hfe;
            op[1] = px_q[31:24];
            op[2] = px_q[23:16];
            op[3] = px_q[15:8];
            op_n  = 3'd4;
        end

        if (px_q == prev_q) begin
            // Run pixel: only a run reaching 62 produces a byte
            if (run_q == 6'd61) begin
                emit_b[0] = 8'hfd;
                emit_n    = 3'd1;
            end
        end else if (run_q != 6'd0) begin
            // A pending run is always flushed ahead of the pixel's own chunk
            emit_b[0] = {2'b11, run_m1};
            for (int i = 0; i < 5; i++) emit_b[i + 1] = op[i];
            emit_n = op_n + 3'd1;
        end else begin
            for (int i = 0; i < 5; i++) emit_b[i] = op[i];
            emit_n = op_n;
        end
    end

    logic [7:0] push_b [6];
    logic [2:0] push_n;

    // Next-state: bus accesses, FSM, FIFO and START handling
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        a_d     = a_q;
        px_d    = px_q;
        prev_d  = prev_q;
        entry_d = entry_q;
        run_d   = run_q;
        hash_d  = hash_q;
        index_d = index_q;
        fifo_d  = fifo_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        for (int i = 0; i < 6; i++) push_b[i] = 8'h00;
        push_n  = 3'd0;

        if (wr) begin
            case (addr)
                4'h0:    r_d = wdata;
                4'h1:    g_d = wdata;
                4'h2:    b_d = wdata;
                4'h3:    a_d = wdata;
                default: ;
            endcase
        end

        if (rd) begin
            case (addr)
                4'h5:    rdata_d = {5'b0, err_q, state_q != StIdle, cnt_q != 4'd0};
                4'h6:    rdata_d = (cnt_q != 4'd0) ? fifo_q[rptr_q] : 8'h00;
                default: rdata_d = 8'h00;
            endcase
        end

        case (state_q)
            StIdle: begin
                if (commit) begin
                    // Six free slots cover the worst case: run flush plus an RGBA chunk
                    if (cnt_q <= 4'd2) begin
                        px_d    = {r_q, g_q, b_q, wdata};
                        state_d = StHash;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (flush) begin
                    // FLUSH is only honoured while idle so it cannot race an EMIT
                    if (run_q != 6'd0 && cnt_q != 4'd8) begin
                        push_b[0] = {2'b11, run_m1};
                        push_n    = 3'd1;
                    end
                    run_d = 6'd0;
                end
            end
            StHash: begin
                if (commit) err_d = 1'b1;
                hash_d  = h_calc;
                entry_d = index_q[h_calc];
                state_d = StEmit;
            end
            StEmit: begin
                if (commit) err_d = 1'b1;
                push_b = emit_b;
                push_n = emit_n;
                if (px_q == prev_q) begin
                    run_d = (run_q == 6'd61) ? 6'd0 : run_q + 6'd1;
                end else begin
                    run_d           = 6'd0;
                    index_d[hash_q] = px_q;
                    prev_d          = px_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (pop) rptr_d = rptr_q + 3'd1;
        for (int i = 0; i < 6; i++) begin
            if (3'(i) < push_n) fifo_d[wptr_q + 3'(i)] = push_b[i];
        end
        wptr_d = wptr_q + push_n;
        cnt_d  = cnt_q + {1'b0, push_n} - {3'b000, pop};

        if (start) begin
            // START overrides everything, including a pixel that is in flight
            state_d = StIdle;
            prev_d  = PrevInit;
            run_d   = 6'd0;
            err_d   = 1'b0;
            wptr_d  = 3'd0;
            rptr_d  = 3'd0;
            cnt_d   = 4'd0;
            for (int i = 0; i < 64; i++) index_d[i] = 32'h0;
        end
    end

    // State registers, asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            r_q     <= 8'h00;
            g_q     <= 8'h00;
            b_q     <= 8'h00;
            a_q     <= 8'h00;
            px_q    <= 32'h0;
            prev_q  <= PrevInit;
            entry_q <= 32'h0;
            run_q   <= 6'd0;
            hash_q  <= 6'd0;
            index_q <= '{default: 32'h0};
            fifo_q  <= '{default: 8'h00};
            wptr_q  <= 3'd0;
            rptr_q  <= 3'd0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            a_q     <= a_d;
            px_q    <= px_d;
            prev_q  <= prev_d;
            entry_q <= entry_d;
            run_q   <= run_d;
            hash_q  <= hash_d;
            index_q <= index_d;
            fifo_q  <= fifo_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

`ifdef QOI_ENC_IRQ_EN
    logic irq_q;

    // Interrupt tracks the next-cycle FIFO/err state so it lines up with STATUS
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq_q <= 1'b0;
        else        irq_q <= (cnt_d != 4'd0) | err_d;
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_qoi_enc_accel.sv
// Directed bench for qoi_enc_accel: bus tasks, hand-computed QOI byte streams.
module tb_qoi_enc_accel;
`ifdef QOI_ENC_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic [3:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq;

    int n_checks = 0;
    int n_pass   = 0;

    qoi_enc_accel u_dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // All bus tasks start and end on a falling edge
    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        cs = 1'b1; we = 1'b0; addr = a;
        @(posedge clk);
        #1 d = rdata;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic expect_data(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        bus_read(4'h6, v);
        check(tag, v, exp);
    endtask

    task automatic expect_status(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        bus_read(4'h5, v);
        check(tag, v, exp);
    endtask

    task automatic do_start();
        bus_write(4'h4, 8'h01);
    endtask

    task automatic commit_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input logic [7:0] a);
        bus_write(4'h0, r);
        bus_write(4'h1, g);
        bus_write(4'h2, b);
        bus_write(4'h3, a);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; cs = 1'b0; we = 1'b0; addr = 4'h0; wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_rdata", {24'h0, rdata}, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        expect_status("post_reset_status", 8'h00);
        expect_data("empty_read", 8'h00);
        check("idle_irq", {31'h0, irq}, 32'h0);

        // INDEX hit on cleared slot 0
        do_start();
        commit_px(8'd0, 8'd0, 8'd0, 8'd0);
        expect_data("index_h0", 8'h00);
        expect_status("status_after_index", 8'h00);

        // DIFF, RGB, LUMA, INDEX, run flush + INDEX, negative DIFF
        do_start();
        commit_px(8'd1, 8'd1, 8'd1, 8'd255);
        expect_data("diff_7f", 8'h7f);
        commit_px(8'd10, 8'd20, 8'd30, 8'd255);
        expect_data("rgb_tag", 8'hfe);
        expect_data("rgb_r", 8'h0a);
        expect_data("rgb_g", 8'h14);
        expect_data("rgb_b", 8'h1e);
        expect_status("status_drained", 8'h00);
        commit_px(8'd20, 8'd30, 8'd40, 8'd255);
        expect_data("luma_b0", 8'haa);
        expect_data("luma_b1", 8'h88);
        commit_px(8'd10, 8'd20, 8'd30, 8'd255);
        expect_data("index_h9", 8'h09);
        commit_px(8'd10, 8'd20, 8'd30, 8'd255);
        commit_px(8'd10, 8'd20, 8'd30, 8'd255);
        commit_px(8'd1, 8'd1, 8'd1, 8'd255);
        expect_data("run2_flush", 8'hc1);
        expect_data("index_h4", 8'h04);
        commit_px(8'd0, 8'd2, 8'd0, 8'd255);
        expect_data("diff_neg", 8'h5d);

        // 62-pixel run emits 0xFD at once; the 63rd starts a new run
        do_start();
        for (int i = 0; i < 63; i++) commit_px(8'd0, 8'd0, 8'd0, 8'd255);
        expect_data("run62", 8'hfd);
        expect_status("run62_empty", 8'h00);
        bus_write(4'h4, 8'h02);
        expect_data("flush_run1", 8'hc0);
        expect_data("flush_then_empty", 8'h00);

        // Alpha change, then the zero pixel still hits cleared index slot 0
        do_start();
        commit_px(8'd5, 8'd5, 8'd5, 8'd128);
        expect_data("rgba_tag", 8'hff);
        expect_data("rgba_r", 8'h05);
        expect_data("rgba_g", 8'h05);
        expect_data("rgba_b", 8'h05);
        expect_data("rgba_a", 8'h80);
        commit_px(8'd0, 8'd0, 8'd0, 8'd0);
        expect_data("zero_px_index", 8'h00);

        // FIFO holding 4 bytes has too little room: commit dropped, err sticky
        do_start();
        commit_px(8'd10, 8'd20, 8'd30, 8'd255);
        commit_px(8'd1, 8'd2, 8'd3, 8'd255);
        expect_status("overflow_status", 8'h05);
        check("overflow_irq", {31'h0, irq}, {31'h0, IrqEn});
        expect_data("ovf_b0", 8'hfe);
        expect_data("ovf_b1", 8'h0a);
        expect_data("ovf_b2", 8'h14);
        expect_data("ovf_b3", 8'h1e);
        expect_status("err_sticky", 8'h04);
        do_start();
        expect_status("start_clears_err", 8'h00);
        check("irq_cleared", {31'h0, irq}, 32'h0);

        // Commit while busy is dropped
        bus_write(4'h0, 8'd1);
        bus_write(4'h1, 8'd1);
        bus_write(4'h2, 8'd1);
        bus_write(4'h3, 8'd255);
        bus_write(4'h3, 8'd255);
        repeat (3) @(negedge clk);
        expect_data("busy_first", 8'h7f);
        expect_data("busy_dropped", 8'h00);
        expect_status("busy_err", 8'h04);

        // Reset asserted while in EMIT
        do_start();
        commit_px(8'd1, 8'd1, 8'd1, 8'd255);
        expect_data("pre_reset_data", 8'h7f);
        bus_write(4'h0, 8'd10);
        bus_write(4'h1, 8'd20);
        bus_write(4'h2, 8'd30);
        bus_write(4'h3, 8'd255);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("emit_reset_rdata", {24'h0, rdata}, 32'h0);
        check("emit_reset_irq", {31'h0, irq}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        expect_status("after_emit_reset", 8'h00);
        do_start();
        commit_px(8'd1, 8'd1, 8'd1, 8'd255);
        expect_data("post_reset_encode", 8'h7f);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
